// File: rtl/nascom_mem_pkg.sv
// Shared types and constants for the NASCOM memory-side models and controllers.
// Holds the EPROM geometry and the read-controller state encoding.
package nascom_mem_pkg;

    localparam int EPROM_ADDR_W = 11;
    localparam int EPROM_DEPTH  = 2048;
    localparam int EPROM_DATA_W = 8;
    localparam int COUNT_W      = 12;
    localparam int TIMER_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        OUT,
        RECOVER
    } rd_state_t;

    // EPROM addresses wrap at the top of the 2K array.
    function automatic logic [EPROM_ADDR_W-1:0] next_addr(input logic [EPROM_ADDR_W-1:0] addr);
        return addr + 11'd1;
    endfunction

endpackage

// File: rtl/eprom_reader_if.sv
// EPROM pin bus plus the captured-byte stream, bundled for the reader and its peers.
// Stream: out_valid stays high with out_data/out_addr frozen until out_ready; a byte transfers on the rising edge where both are high.
interface eprom_reader_if;
    import nascom_mem_pkg::*;

    logic [EPROM_ADDR_W-1:0] a;
    logic                    cs_n;
    logic                    oe_n;
    logic [EPROM_DATA_W-1:0] d_in;
    logic [EPROM_DATA_W-1:0] out_data;
    logic [EPROM_ADDR_W-1:0] out_addr;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output a, cs_n, oe_n, out_data, out_addr, out_valid,
        input  d_in, out_ready
    );

    modport slave (
        input  a, cs_n, oe_n, out_data, out_addr, out_valid,
        output d_in, out_ready
    );

endinterface

// File: rtl/rom_wait_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Loading N gives N+1 cycles in the current state before tc ends it.
module rom_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/eprom_reader.sv
// Burst reader for a 2716-style EPROM: timed CS/OE read cycles, bytes streamed
// out over valid/ready with a running modulo-256 checksum of accepted bytes.
module eprom_reader
    import nascom_mem_pkg::*;
#(
    parameter int ACCESS_CYC  = 4,
    parameter int RECOVER_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [EPROM_ADDR_W-1:0] base_addr,
    input  logic [COUNT_W-1:0]      count,
    output logic                    busy,
    output logic                    done,
    output logic [EPROM_DATA_W-1:0] checksum,
    output rd_state_t               dbg_state,
    eprom_reader_if.master          bus
);

    localparam logic [TIMER_W-1:0] ACCESS_LOAD  = TIMER_W'(ACCESS_CYC - 1);
    localparam logic [TIMER_W-1:0] RECOVER_LOAD = (RECOVER_CYC > 0) ? TIMER_W'(RECOVER_CYC - 1) : '0;

    rd_state_t               state;
    logic [EPROM_ADDR_W-1:0] addr;
    logic [COUNT_W-1:0]      remaining;
    logic                    handshake;
    logic                    last_byte;
    logic                    tmr_load;
    logic [TIMER_W-1:0]      tmr_val;
    logic                    tmr_tc;

    assign handshake = (state == OUT) && bus.out_valid && bus.out_ready;
    assign last_byte = (remaining == 12'd1);
    assign dbg_state = state;

    // The one timer is armed on entry to ACCESS and on entry to RECOVER.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = ACCESS_LOAD;
        if (state == SETUP) begin
            tmr_load = 1'b1;
        end else if (handshake && !last_byte) begin
            tmr_load = 1'b1;
            tmr_val  = RECOVER_LOAD;
        end
    end

    rom_wait_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            checksum      <= '0;
            bus.a         <= '0;
            bus.cs_n      <= 1'b1;
            bus.oe_n      <= 1'b1;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    bus.cs_n <= 1'b1;
                    bus.oe_n <= 1'b1;
                    // A start coinciding with the done pulse belongs to the old burst.
                    if (start && !done) begin
                        addr      <= base_addr;
                        remaining <= count;
                        checksum  <= '0;
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            busy     <= 1'b1;
                            bus.a    <= base_addr;
                            bus.cs_n <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    bus.oe_n <= 1'b0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (tmr_tc) begin
                        bus.out_data  <= bus.d_in;
                        bus.out_addr  <= addr;
                        bus.out_valid <= 1'b1;
                        bus.cs_n      <= 1'b1;
                        bus.oe_n      <= 1'b1;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (handshake) begin
                        bus.out_valid <= 1'b0;
                        checksum      <= checksum + bus.out_data;
                        addr          <= next_addr(addr);
                        remaining     <= remaining - 12'd1;
                        if (last_byte) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (RECOVER_CYC == 0) begin
                            bus.a    <= next_addr(addr);
                            bus.cs_n <= 1'b0;
                            state    <= SETUP;
                        end else begin
                            state <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    if (tmr_tc) begin
                        bus.a    <= addr;
                        bus.cs_n <= 1'b0;
                        state    <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eprom_reader.sv
// Randomized bench for eprom_reader: EPROM array model, expected-byte queue,
// and cycle-level timing expectations derived from the access/recover budget.
module tb_eprom_reader;
    import nascom_mem_pkg::*;

    localparam int ACC = 4;
    localparam int REC = 1;
    localparam int PERIOD = 2 + ACC + REC;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [EPROM_ADDR_W-1:0] base_addr;
    logic [COUNT_W-1:0]      count;
    logic                    busy;
    logic                    done;
    logic [7:0]              checksum;
    rd_state_t               dbg_state;

    eprom_reader_if bus();

    eprom_reader #(.ACCESS_CYC(ACC), .RECOVER_CYC(REC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- EPROM model ----------------
    logic [7:0] rom [0:EPROM_DEPTH-1];
    bit         const_mode = 1'b0;
    logic [7:0] rom_q;

    always_comb rom_q = const_mode ? 8'hAA : rom[bus.a];
    assign bus.d_in = (!bus.cs_n && !bus.oe_n) ? rom_q : 8'hzz;

    function automatic logic [7:0] model_byte(input int addr);
        return const_mode ? 8'hAA : rom[addr];
    endfunction

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [18:0] exp_q[$];     // {addr, data} of each byte still to be delivered
    logic [10:0] exp_a_q[$];   // addresses of EPROM accesses still to be made

    int  access_cnt = 0;
    int  done_cnt = 0;
    int  hs_cnt = 0;
    int  last_hs_cyc = 0;
    int  first_valid_cyc = -1;
    bit  check_period = 1'b0;
    logic prev_cs_n = 1'b1;
    int  ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.oe_n) check("oe_needs_cs", bus.cs_n, 0);
            if (!bus.cs_n && prev_cs_n) begin
                access_cnt++;
                check("access_expected", exp_a_q.size() != 0, 1);
                if (exp_a_q.size() != 0) check("bus_addr", bus.a, exp_a_q.pop_front());
            end
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("out_bus_idle", {bus.cs_n, bus.oe_n}, 2'b11);
                check("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", bus.out_data, exp_q[0][7:0]);
                    check("out_addr", bus.out_addr, exp_q[0][18:8]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                        if (check_period && hs_cnt > 1) check("byte_period", cyc - last_hs_cyc, PERIOD);
                        last_hs_cyc = cyc;
                    end
                end
            end
            if (done) done_cnt++;
        end
        prev_cs_n = bus.cs_n;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 2) != 0);
            default: ;
        endcase
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ten-cycle stall on first byte
    task automatic run_burst(input int b, input int n, input int rmode, input bit poke);
        int t0, sum, waited, stall, acc0, done0, budget;
        exp_q.delete();
        exp_a_q.delete();
        sum = 0;
        for (int i = 0; i < n; i++) begin
            int ad;
            ad = (b + i) % EPROM_DEPTH;
            exp_a_q.push_back(11'(ad));
            exp_q.push_back({11'(ad), model_byte(ad)});
            sum = (sum + model_byte(ad)) % 256;
        end
        ready_mode = rmode;
        check_period = (rmode == 0);
        if (rmode == 2) bus.out_ready = 1'b0;
        hs_cnt = 0;
        first_valid_cyc = -1;
        acc0 = access_cnt;
        done0 = done_cnt;
        stall = 0;
        budget = n * PERIOD * 4 + 60;

        base_addr = 11'(b);
        count = 12'(n);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        base_addr = 11'($urandom);
        count = 12'($urandom);

        if (poke) begin
            while (cyc < t0 + 3) tick();
            start = 1'b1;
            base_addr = 11'(b) ^ 11'h400;
            count = 12'd5;
            tick();
            start = 1'b0;
        end

        waited = 0;
        while (!done && waited < budget) begin
            if (rmode == 2) begin
                if (bus.out_valid && stall < 10) begin
                    bus.out_ready = 1'b0;
                    stall++;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
            tick();
            waited++;
        end
        check("done_seen", done, 1);
        check("done_after_last_hs", cyc, last_hs_cyc + 1);
        check("busy_at_done", busy, 1);
        check("first_valid_latency", first_valid_cyc - t0, 2 + ACC);
        check("bytes_delivered", hs_cnt, n);
        if (rmode == 2) check("stall_cycles", stall, 10);
        for (int i = 0; i < 3; i++) tick();
        check("done_pulses", done_cnt - done0, 1);
        check("eprom_accesses", access_cnt - acc0, n);
        check("checksum", checksum, sum);
        check("busy_after", busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_zero();
        int acc0, done0;
        acc0 = access_cnt;
        done0 = done_cnt;
        base_addr = 11'($urandom);
        count = 12'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_checksum", checksum, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zero_busy_hold", busy, 0);
        end
        check("zero_done_pulses", done_cnt - done0, 1);
        check("zero_accesses", access_cnt - acc0, 0);
    endtask

    task automatic run_reset_mid();
        int t0, done0;
        exp_q.delete();
        exp_a_q.delete();
        exp_a_q.push_back(11'h055);
        ready_mode = 0;
        done0 = done_cnt;
        base_addr = 11'h055;
        count = 12'd3;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        while (cyc < t0 + 3) tick();
        check("rst_in_access", {bus.cs_n, bus.oe_n}, 2'b00);
        rst = 1'b1;
        tick();
        check("rst_cs_oe", {bus.cs_n, bus.oe_n}, 2'b11);
        check("rst_valid", bus.out_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_a_q.delete();
        for (int i = 0; i < 4; i++) tick();
        check("rst_no_done", done_cnt - done0, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        bus.out_ready = 1'b0;
        ready_mode = 2;
        for (int i = 0; i < EPROM_DEPTH; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) tick();
        check("rst_a", bus.a, 0);
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_oe_n", bus.oe_n, 1);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_checksum", checksum, 0);
        check("rst_busy_r", busy, 0);
        check("rst_done_r", done, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        tick();

        const_mode = 1'b1;
        run_burst(0, 4, 0, 1'b0);
        check("basic_checksum", checksum, 8'hA8);
        const_mode = 1'b0;

        run_burst(11'h7FE, 3, 0, 1'b0);
        run_burst($urandom_range(0, EPROM_DEPTH - 1), 3, 2, 1'b0);
        run_zero();
        run_reset_mid();
        run_burst($urandom_range(0, EPROM_DEPTH - 1), 2, 1, 1'b0);
        run_burst(11'h123, 3, 0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            run_burst($urandom_range(0, EPROM_DEPTH - 1), $urandom_range(1, 12),
                      $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
